// File: rtl/xava_xif_tracker_if.sv
// CV-X-IF issue/commit/result channels plus the accelerator_top APU port, bundled for xava_xif_tracker.
// The tracker connects through the slave modport; the core/accelerator side uses master.
interface xava_xif_tracker_if #(
    parameter int ID_W = 4,
    parameter int XLEN = 32
);
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [ID_W-1:0]     issue_id_i;
    logic [XLEN-1:0]     issue_rs0_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic                issue_accept_o;
    logic                issue_writeback_o;
    logic                commit_valid_i;
    logic [ID_W-1:0]     commit_id_i;
    logic                commit_kill_i;
    logic                apu_req_o;
    logic [3*XLEN-1:0]   apu_operands_o;
    logic                apu_gnt_i;
    logic                apu_rvalid_i;
    logic [XLEN-1:0]     apu_result_i;
    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_W-1:0]     result_id_o;
    logic [XLEN-1:0]     result_data_o;
    logic [4:0]          result_rd_o;
    logic                result_we_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        input  apu_gnt_i, apu_rvalid_i, apu_result_i, result_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
        output apu_req_o, apu_operands_o,
        output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        output apu_gnt_i, apu_rvalid_i, apu_result_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
        input  apu_req_o, apu_operands_o,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );
endinterface

// File: rtl/xava_xif_tracker.sv
// In-order X-IF offload tracker: buffers issued vector instructions until commit/kill, dispatches them to the APU.
// Optional XAVA_RESULT_REG_EN adds a one-entry result buffer so dispatch can continue while a result waits.
module xava_xif_tracker #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int XLEN  = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    xava_xif_tracker_if.slave xif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [6:0] OPC_OP_V     = 7'b1010111;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

    typedef enum logic [1:0] {ENT_ISSUED, ENT_COMMITTED, ENT_KILLED} ent_state_e;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} fsm_state_e;

    logic            ent_valid_q [DEPTH];
    logic            ent_valid_d [DEPTH];
    ent_state_e      ent_state_q [DEPTH];
    ent_state_e      ent_state_d [DEPTH];
    logic [ID_W-1:0] ent_id_q    [DEPTH];
    logic [ID_W-1:0] ent_id_d    [DEPTH];
    logic [31:0]     ent_instr_q [DEPTH];
    logic [31:0]     ent_instr_d [DEPTH];
    logic [XLEN-1:0] ent_rs0_q   [DEPTH];
    logic [XLEN-1:0] ent_rs0_d   [DEPTH];
    logic [XLEN-1:0] ent_rs1_q   [DEPTH];
    logic [XLEN-1:0] ent_rs1_d   [DEPTH];
    logic            ent_wb_q    [DEPTH];
    logic            ent_wb_d    [DEPTH];

    logic [PTR_W:0]  head_q, head_d, tail_q, tail_d;
    fsm_state_e      fsm_q, fsm_d;

    logic [XLEN-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [4:0]      res_rd_q, res_rd_d;
    logic            res_we_q, res_we_d;
`ifdef XAVA_RESULT_REG_EN
    logic            res_valid_q, res_valid_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_data_q, pend_data_d;
    logic            buf_free;
`endif

    logic [PTR_W-1:0] head_idx, tail_idx;
    logic             empty, full, alloc, pop, capture;
    logic [XLEN-1:0]  capture_data;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [5:0]       funct6;
    logic             dec_accept, dec_wb;
    logic [XLEN-1:0]  head_instr_ext;

    assign head_idx = head_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_q[PTR_W] != tail_q[PTR_W]) && (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);

    assign opcode     = xif.issue_instr_i[6:0];
    assign funct3     = xif.issue_instr_i[14:12];
    assign funct6     = xif.issue_instr_i[31:26];
    assign dec_accept = (opcode == OPC_OP_V) || (opcode == OPC_LOAD_FP) || (opcode == OPC_STORE_FP);
    // vsetvl* and vmv.x.s are the only vector ops here that write an x-register
    assign dec_wb     = (opcode == OPC_OP_V) &&
                        ((funct3 == 3'b111) || ((funct3 == 3'b010) && (funct6 == 6'b010000)));

    assign alloc = xif.issue_valid_i && !full && dec_accept;

    assign xif.issue_ready_o     = !full;
    assign xif.issue_accept_o    = dec_accept;
    assign xif.issue_writeback_o = dec_wb;

    assign head_instr_ext     = XLEN'(ent_instr_q[head_idx]);
    assign xif.apu_req_o      = (fsm_q == S_REQ);
    assign xif.apu_operands_o = (fsm_q == S_REQ)
                              ? {ent_rs1_q[head_idx], ent_rs0_q[head_idx], head_instr_ext}
                              : '0;

`ifdef XAVA_RESULT_REG_EN
    assign buf_free           = !res_valid_q || xif.result_ready_i;
    assign xif.result_valid_o = res_valid_q;
`else
    assign xif.result_valid_o = (fsm_q == S_RESP);
`endif
    assign xif.result_id_o   = res_id_q;
    assign xif.result_data_o = res_data_q;
    assign xif.result_rd_o   = res_rd_q;
    assign xif.result_we_o   = res_we_q;

    always_comb begin
        fsm_d        = fsm_q;
        pop          = 1'b0;
        capture      = 1'b0;
        capture_data = xif.apu_result_i;
`ifdef XAVA_RESULT_REG_EN
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
`endif
        case (fsm_q)
            S_IDLE: begin
                if (!empty) begin
                    if (ent_state_q[head_idx] == ENT_KILLED) begin
                        pop = 1'b1;
                    end else if (ent_state_q[head_idx] == ENT_COMMITTED) begin
                        fsm_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (xif.apu_gnt_i) begin
                    fsm_d = S_WAIT;
                    if (xif.apu_rvalid_i) begin
`ifdef XAVA_RESULT_REG_EN
                        if (buf_free) begin
                            capture = 1'b1;
                            pop     = 1'b1;
                            fsm_d   = S_IDLE;
                        end else begin
                            pend_d      = 1'b1;
                            pend_data_d = xif.apu_result_i;
                        end
`else
                        capture = 1'b1;
                        fsm_d   = S_RESP;
`endif
                    end
                end
            end
            S_WAIT: begin
`ifdef XAVA_RESULT_REG_EN
                // A result that arrived while the buffer was occupied is parked in pend until it drains
                if (pend_q || xif.apu_rvalid_i) begin
                    if (buf_free) begin
                        capture      = 1'b1;
                        capture_data = pend_q ? pend_data_q : xif.apu_result_i;
                        pop          = 1'b1;
                        pend_d       = 1'b0;
                        fsm_d        = S_IDLE;
                    end else if (!pend_q) begin
                        pend_d      = 1'b1;
                        pend_data_d = xif.apu_result_i;
                    end
                end
`else
                if (xif.apu_rvalid_i) begin
                    capture = 1'b1;
                    fsm_d   = S_RESP;
                end
`endif
            end
            S_RESP: begin
`ifdef XAVA_RESULT_REG_EN
                fsm_d = S_IDLE;
`else
                if (xif.result_ready_i) begin
                    pop   = 1'b1;
                    fsm_d = S_IDLE;
                end
`endif
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        res_rd_d   = res_rd_q;
        res_we_d   = res_we_q;
`ifdef XAVA_RESULT_REG_EN
        res_valid_d = res_valid_q && !xif.result_ready_i;
`endif
        if (capture) begin
            res_data_d = capture_data;
            res_id_d   = ent_id_q[head_idx];
            res_rd_d   = ent_instr_q[head_idx][11:7];
            res_we_d   = ent_wb_q[head_idx];
`ifdef XAVA_RESULT_REG_EN
            res_valid_d = 1'b1;
`endif
        end
    end

    always_comb begin
        ent_valid_d = ent_valid_q;
        ent_state_d = ent_state_q;
        ent_id_d    = ent_id_q;
        ent_instr_d = ent_instr_q;
        ent_rs0_d   = ent_rs0_q;
        ent_rs1_d   = ent_rs1_q;
        ent_wb_d    = ent_wb_q;
        head_d      = head_q + {{PTR_W{1'b0}}, pop};
        tail_d      = tail_q + {{PTR_W{1'b0}}, alloc};
        for (int i = 0; i < DEPTH; i++) begin
            if (xif.commit_valid_i && ent_valid_q[i] && (ent_id_q[i] == xif.commit_id_i)) begin
                ent_state_d[i] = xif.commit_kill_i ? ENT_KILLED : ENT_COMMITTED;
            end
        end
        if (pop) begin
            ent_valid_d[head_idx] = 1'b0;
        end
        // A commit for the ID being allocated this cycle lands on the new entry
        if (alloc) begin
            ent_valid_d[tail_idx] = 1'b1;
            ent_id_d[tail_idx]    = xif.issue_id_i;
            ent_instr_d[tail_idx] = xif.issue_instr_i;
            ent_rs0_d[tail_idx]   = xif.issue_rs0_i;
            ent_rs1_d[tail_idx]   = xif.issue_rs1_i;
            ent_wb_d[tail_idx]    = dec_wb;
            if (xif.commit_valid_i && (xif.commit_id_i == xif.issue_id_i)) begin
                ent_state_d[tail_idx] = xif.commit_kill_i ? ENT_KILLED : ENT_COMMITTED;
            end else begin
                ent_state_d[tail_idx] = ENT_ISSUED;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid_q[i] <= 1'b0;
                ent_state_q[i] <= ENT_ISSUED;
                ent_id_q[i]    <= '0;
                ent_instr_q[i] <= '0;
                ent_rs0_q[i]   <= '0;
                ent_rs1_q[i]   <= '0;
                ent_wb_q[i]    <= 1'b0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            fsm_q      <= S_IDLE;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_rd_q   <= '0;
            res_we_q   <= 1'b0;
`ifdef XAVA_RESULT_REG_EN
            res_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
`endif
        end else begin
            ent_valid_q <= ent_valid_d;
            ent_state_q <= ent_state_d;
            ent_id_q    <= ent_id_d;
            ent_instr_q <= ent_instr_d;
            ent_rs0_q   <= ent_rs0_d;
            ent_rs1_q   <= ent_rs1_d;
            ent_wb_q    <= ent_wb_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fsm_q       <= fsm_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_rd_q    <= res_rd_d;
            res_we_q    <= res_we_d;
`ifdef XAVA_RESULT_REG_EN
            res_valid_q <= res_valid_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
`endif
        end
    end
endmodule

// File: tb/tb_xava_xif_tracker.sv
// Directed bench for xava_xif_tracker: one task per scenario, hand-computed expectations.
module tb_xava_xif_tracker;
    localparam logic [31:0] I_VSETVLI = 32'h010572D7;
    localparam logic [31:0] I_VADD    = 32'h02208057;
    localparam logic [31:0] I_VMVXS   = 32'h423023D7;
    localparam logic [31:0] I_VREDSUM = 32'h02202057;
    localparam logic [31:0] I_LOADFP  = 32'h00006007;
    localparam logic [31:0] I_STOREFP = 32'h00006027;
    localparam logic [31:0] I_ADD     = 32'h002081B3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    xava_xif_tracker_if #(.ID_W(4), .XLEN(32)) xif ();

    xava_xif_tracker #(.DEPTH(4), .ID_W(4), .XLEN(32)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .xif   (xif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        xif.issue_valid_i  = 1'b0;
        xif.issue_instr_i  = '0;
        xif.issue_id_i     = '0;
        xif.issue_rs0_i    = '0;
        xif.issue_rs1_i    = '0;
        xif.commit_valid_i = 1'b0;
        xif.commit_id_i    = '0;
        xif.commit_kill_i  = 1'b0;
        xif.apu_gnt_i      = 1'b0;
        xif.apu_rvalid_i   = 1'b0;
        xif.apu_result_i   = '0;
        xif.result_ready_i = 1'b0;
    endtask

    task automatic do_issue(input logic [31:0] instr, input logic [3:0] id,
                            input logic [31:0] rs0, input logic [31:0] rs1);
        xif.issue_valid_i = 1'b1;
        xif.issue_instr_i = instr;
        xif.issue_id_i    = id;
        xif.issue_rs0_i   = rs0;
        xif.issue_rs1_i   = rs1;
        step();
        xif.issue_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        xif.commit_valid_i = 1'b1;
        xif.commit_id_i    = id;
        xif.commit_kill_i  = kill;
        step();
        xif.commit_valid_i = 1'b0;
        xif.commit_kill_i  = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        for (int i = 0; i < 20; i++) begin
            if (xif.apu_req_o) break;
            step();
        end
        ok = xif.apu_req_o;
    endtask

    task automatic wait_result(output bit ok);
        for (int i = 0; i < 20; i++) begin
            if (xif.result_valid_o) break;
            step();
        end
        ok = xif.result_valid_o;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++; if (xif.apu_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%0b exp=0", xif.apu_req_o); end
        checks++; if (xif.result_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid got=%0b exp=0", xif.result_valid_o); end
        checks++; if (xif.issue_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=1", xif.issue_ready_o); end
        checks++; if (xif.apu_operands_o !== 96'h0) begin failures++; $display("[TB] FAIL reset_operands got=%h exp=0", xif.apu_operands_o); end
        checks++; if (xif.result_data_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", xif.result_data_o); end
        checks++; if (xif.result_id_o !== 4'h0) begin failures++; $display("[TB] FAIL reset_id got=%h exp=0", xif.result_id_o); end
        release_reset();
    endtask

    task automatic test_decode();
        logic [31:0] instrs [7];
        logic        exp_acc [7];
        logic        exp_wb [7];
        instrs  = '{I_VSETVLI, I_VADD, I_VMVXS, I_VREDSUM, I_LOADFP, I_STOREFP, I_ADD};
        exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_wb  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            xif.issue_instr_i = instrs[i];
            #1;
            checks++; if (xif.issue_accept_o !== exp_acc[i]) begin failures++; $display("[TB] FAIL decode_accept[%0d] got=%0b exp=%0b", i, xif.issue_accept_o, exp_acc[i]); end
            checks++; if (xif.issue_writeback_o !== exp_wb[i]) begin failures++; $display("[TB] FAIL decode_wb[%0d] got=%0b exp=%0b", i, xif.issue_writeback_o, exp_wb[i]); end
        end
        xif.issue_instr_i = '0;
    endtask

    task automatic test_single();
        do_issue(I_VSETVLI, 4'd3, 32'hA, 32'hB);
        do_commit(4'd3, 1'b0);
        checks++; if (xif.apu_req_o !== 1'b0) begin failures++; $display("[TB] FAIL single_req_early got=%0b exp=0", xif.apu_req_o); end
        step();
        checks++; if (xif.apu_req_o !== 1'b1) begin failures++; $display("[TB] FAIL single_req got=%0b exp=1", xif.apu_req_o); end
        checks++; if (xif.apu_operands_o !== {32'hB, 32'hA, I_VSETVLI}) begin failures++; $display("[TB] FAIL single_operands got=%h exp=%h", xif.apu_operands_o, {32'hB, 32'hA, I_VSETVLI}); end
        xif.apu_gnt_i = 1'b1; xif.apu_rvalid_i = 1'b1; xif.apu_result_i = 32'h10;
        step();
        xif.apu_gnt_i = 1'b0; xif.apu_rvalid_i = 1'b0;
        checks++; if (xif.result_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL single_latency got=%0b exp=1", xif.result_valid_o); end
        checks++; if (xif.result_id_o !== 4'd3) begin failures++; $display("[TB] FAIL single_id got=%0d exp=3", xif.result_id_o); end
        checks++; if (xif.result_data_o !== 32'h10) begin failures++; $display("[TB] FAIL single_data got=%h exp=10", xif.result_data_o); end
        checks++; if (xif.result_we_o !== 1'b1) begin failures++; $display("[TB] FAIL single_we got=%0b exp=1", xif.result_we_o); end
        checks++; if (xif.result_rd_o !== 5'd5) begin failures++; $display("[TB] FAIL single_rd got=%0d exp=5", xif.result_rd_o); end
        xif.result_ready_i = 1'b1;
        step();
        xif.result_ready_i = 1'b0;
        checks++; if (xif.result_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL single_drop got=%0b exp=0", xif.result_valid_o); end
    endtask

    task automatic test_full();
        bit ok;
        for (int i = 0; i < 4; i++) do_issue(I_VADD, 4'(i), 32'(i), 32'h0);
        checks++; if (xif.issue_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%0b exp=0", xif.issue_ready_o); end
        do_commit(4'd0, 1'b0);
        wait_req(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL full_req_timeout got=0 exp=1"); end
        xif.apu_gnt_i = 1'b1; xif.apu_rvalid_i = 1'b1; xif.apu_result_i = 32'h21;
        step();
        xif.apu_gnt_i = 1'b0; xif.apu_rvalid_i = 1'b0;
        checks++; if (xif.result_id_o !== 4'd0 || xif.result_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL full_result got=v%0b/id%0d exp=v1/id0", xif.result_valid_o, xif.result_id_o); end
`ifndef XAVA_RESULT_REG_EN
        checks++; if (xif.issue_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_hold got=%0b exp=0", xif.issue_ready_o); end
`endif
        xif.result_ready_i = 1'b1;
        step();
        xif.result_ready_i = 1'b0;
        checks++; if (xif.issue_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_back got=%0b exp=1", xif.issue_ready_o); end
        for (int i = 1; i < 4; i++) do_commit(4'(i), 1'b1);
        for (int c = 0; c < 4; c++) begin
            checks++; if (xif.apu_req_o !== 1'b0 || xif.result_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL full_kill_quiet got=req%0b/rv%0b exp=0/0", xif.apu_req_o, xif.result_valid_o); end
            step();
        end
        // after the kills drain, exactly four more issues fill the table again (pointer wrap)
        for (int i = 0; i < 3; i++) do_issue(I_VADD, 4'(8 + i), 32'h0, 32'h0);
        checks++; if (xif.issue_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL wrap_ready3 got=%0b exp=1", xif.issue_ready_o); end
        do_issue(I_VADD, 4'd11, 32'h0, 32'h0);
        checks++; if (xif.issue_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL wrap_ready4 got=%0b exp=0", xif.issue_ready_o); end
        for (int i = 0; i < 4; i++) do_commit(4'(8 + i), 1'b1);
        for (int c = 0; c < 5; c++) step();
        checks++; if (xif.issue_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL wrap_drain got=%0b exp=1", xif.issue_ready_o); end
    endtask

    task automatic test_kill();
        int reqs = 0;
        int results = 0;
        do_issue(I_VADD, 4'd1, 32'h1, 32'h2);
        do_issue(I_VMVXS, 4'd2, 32'h1234, 32'h0);
        do_commit(4'd1, 1'b1);
        do_commit(4'd2, 1'b0);
        for (int c = 0; c < 15; c++) begin
            xif.apu_gnt_i = 1'b0; xif.apu_rvalid_i = 1'b0; xif.result_ready_i = 1'b0;
            if (xif.apu_req_o) begin
                reqs++;
                checks++; if (xif.apu_operands_o[31:0] !== I_VMVXS) begin failures++; $display("[TB] FAIL kill_instr got=%h exp=%h", xif.apu_operands_o[31:0], I_VMVXS); end
                xif.apu_gnt_i = 1'b1; xif.apu_rvalid_i = 1'b1; xif.apu_result_i = 32'h55;
            end
            if (xif.result_valid_o) begin
                results++;
                checks++; if (xif.result_id_o !== 4'd2) begin failures++; $display("[TB] FAIL kill_id got=%0d exp=2", xif.result_id_o); end
                checks++; if (xif.result_data_o !== 32'h55) begin failures++; $display("[TB] FAIL kill_data got=%h exp=55", xif.result_data_o); end
                checks++; if (xif.result_we_o !== 1'b1 || xif.result_rd_o !== 5'd7) begin failures++; $display("[TB] FAIL kill_we_rd got=%0b/%0d exp=1/7", xif.result_we_o, xif.result_rd_o); end
                xif.result_ready_i = 1'b1;
            end
            step();
        end
        idle_inputs();
        checks++; if (reqs != 1) begin failures++; $display("[TB] FAIL kill_reqs got=%0d exp=1", reqs); end
        checks++; if (results != 1) begin failures++; $display("[TB] FAIL kill_results got=%0d exp=1", results); end
    endtask

    task automatic test_stall();
        bit ok;
        bit exp_req_seen;
        int reqs = 0;
`ifdef XAVA_RESULT_REG_EN
        exp_req_seen = 1'b1;
`else
        exp_req_seen = 1'b0;
`endif
        do_issue(I_VSETVLI, 4'd4, 32'h0, 32'h0);
        do_issue(I_VADD, 4'd5, 32'h0, 32'h0);
        do_commit(4'd4, 1'b0);
        do_commit(4'd5, 1'b0);
        wait_req(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL stall_req1_timeout got=0 exp=1"); end
        xif.apu_gnt_i = 1'b1; xif.apu_rvalid_i = 1'b1; xif.apu_result_i = 32'h77;
        step();
        xif.apu_gnt_i = 1'b0; xif.apu_rvalid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (xif.result_valid_o !== 1'b1 || xif.result_id_o !== 4'd4 || xif.result_data_o !== 32'h77) begin failures++; $display("[TB] FAIL stall_hold[%0d] got=v%0b/id%0d/%h exp=v1/id4/77", c, xif.result_valid_o, xif.result_id_o, xif.result_data_o); end
            if (xif.apu_req_o) reqs++;
            step();
        end
        checks++; if ((reqs > 0) != exp_req_seen) begin failures++; $display("[TB] FAIL stall_dispatch got=%0d exp_seen=%0b", reqs, exp_req_seen); end
        xif.result_ready_i = 1'b1;
        step();
        xif.result_ready_i = 1'b0;
        wait_req(ok);
        checks++; if (!ok || xif.apu_operands_o[31:0] !== I_VADD) begin failures++; $display("[TB] FAIL stall_req2 got=%0b/%h exp=1/%h", ok, xif.apu_operands_o[31:0], I_VADD); end
        xif.apu_gnt_i = 1'b1; xif.apu_rvalid_i = 1'b1; xif.apu_result_i = 32'h88;
        step();
        xif.apu_gnt_i = 1'b0; xif.apu_rvalid_i = 1'b0;
        wait_result(ok);
        checks++; if (!ok || xif.result_id_o !== 4'd5 || xif.result_data_o !== 32'h88 || xif.result_we_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_result2 got=v%0b/id%0d/%h/we%0b exp=v1/id5/88/we0", ok, xif.result_id_o, xif.result_data_o, xif.result_we_o); end
        xif.result_ready_i = 1'b1;
        step();
        xif.result_ready_i = 1'b0;
    endtask

    task automatic test_reject();
        xif.issue_valid_i = 1'b1;
        xif.issue_instr_i = I_ADD;
        xif.issue_id_i    = 4'd6;
        #1;
        checks++; if (xif.issue_accept_o !== 1'b0 || xif.issue_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reject_handshake got=acc%0b/rdy%0b exp=0/1", xif.issue_accept_o, xif.issue_ready_o); end
        step();
        xif.issue_valid_i = 1'b0;
        do_commit(4'd6, 1'b0);
        for (int c = 0; c < 6; c++) begin
            checks++; if (xif.apu_req_o !== 1'b0 || xif.result_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reject_quiet got=req%0b/rv%0b exp=0/0", xif.apu_req_o, xif.result_valid_o); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_issue(I_VSETVLI, 4'd7, 32'h0, 32'h0);
        do_issue(I_VADD, 4'd8, 32'h0, 32'h0);
        do_issue(I_VADD, 4'd9, 32'h0, 32'h0);
        do_issue(I_VADD, 4'd10, 32'h0, 32'h0);
        do_commit(4'd7, 1'b0);
        wait_req(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rstmid_req_timeout got=0 exp=1"); end
        xif.apu_gnt_i = 1'b1;
        step();
        xif.apu_gnt_i = 1'b0;
        checks++; if (xif.apu_req_o !== 1'b0 || xif.issue_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_wait got=req%0b/rdy%0b exp=0/0", xif.apu_req_o, xif.issue_ready_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (xif.apu_req_o !== 1'b0 || xif.result_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_outputs got=req%0b/rv%0b exp=0/0", xif.apu_req_o, xif.result_valid_o); end
        checks++; if (xif.issue_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_ready got=%0b exp=1", xif.issue_ready_o); end
        release_reset();
        xif.apu_rvalid_i = 1'b1; xif.apu_result_i = 32'h99;
        step();
        xif.apu_rvalid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (xif.result_valid_o !== 1'b0 || xif.apu_req_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_stray got=rv%0b/req%0b exp=0/0", xif.result_valid_o, xif.apu_req_o); end
            step();
        end
        do_issue(I_VSETVLI, 4'd1, 32'h0, 32'h0);
        do_commit(4'd1, 1'b0);
        wait_req(ok);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (!ok || xif.apu_req_o !== 1'b0) begin failures++; $display("[TB] FAIL rstreq_async got=seen%0b/req%0b exp=1/0", ok, xif.apu_req_o); end
        release_reset();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_single();
        test_full();
        test_kill();
        test_stall();
        test_reject();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
